// File: rtl/mbox_rd_if_if.sv
// Bundle between the MAILBOX read side and its FIFO / word consumer.
// master = reassembler, slave = FIFO plus downstream consumer.
interface mbox_rd_if_if #(
    parameter int WB_DW  = 32,
    parameter int WOU_DW = 8,
    parameter int CNT_W  = 16
);
    logic              mbox_rd_o;
    logic [WOU_DW-1:0] mbox_di_i;
    logic              mbox_empty_i;
    logic              flush_i;
    logic [WB_DW-1:0]  word_o;
    logic              word_vld_o;
    logic              word_rdy_i;
    logic              partial_o;
    logic [CNT_W-1:0]  word_cnt_o;

    modport master (
        output mbox_rd_o, word_o, word_vld_o, partial_o, word_cnt_o,
        input  mbox_di_i, mbox_empty_i, flush_i, word_rdy_i
    );

    modport slave (
        input  mbox_rd_o, word_o, word_vld_o, partial_o, word_cnt_o,
        output mbox_di_i, mbox_empty_i, flush_i, word_rdy_i
    );
endinterface

// File: rtl/mbox_rd_if.sv
// MAILBOX read side: pops bytes LSB first and reassembles 32-bit words
// onto a valid/ready output register.
module mbox_rd_if #(
    parameter int WB_DW  = 32,
    parameter int WOU_DW = 8,
    parameter int CNT_W  = 16
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    mbox_rd_if_if.master bus
);
    localparam int NB = WB_DW / WOU_DW;
    localparam logic [2:0] LAST = 3'(NB - 1);
    localparam logic [2:0] FULL = 3'(NB);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]       n_iss;
    logic [2:0]       n_cap;
    logic             rd_pend;
    logic [WB_DW-1:0] shift_buf;
    logic [WB_DW-1:0] word;
    logic             vld;
    logic [CNT_W-1:0] cnt;

    logic             rd;
    logic             out_free;
    logic             direct;
    logic             held;
    logic             load;
    logic [WB_DW-1:0] cap_word;

    assign rd       = ~bus.mbox_empty_i & (n_iss < FULL) & ~bus.flush_i;
    assign cap_word = {bus.mbox_di_i, shift_buf[WB_DW-1:WOU_DW]};
    assign out_free = ~vld | bus.word_rdy_i;

    // 4th byte arriving straight into a free output, or a parked word
    // in HOLD leaving once the consumer frees the register.
    assign direct = rd_pend & (n_cap == LAST) & out_free & ~bus.flush_i;
    assign held   = (n_cap == FULL) & out_free & ~bus.flush_i;
    assign load   = direct | held;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            n_iss     <= '0;
            n_cap     <= '0;
            rd_pend   <= 1'b0;
            shift_buf <= '0;
            word      <= '0;
            vld       <= 1'b0;
            cnt       <= '0;
        end else begin
            rd_pend <= rd;
            if (bus.flush_i) begin
                n_iss     <= '0;
                n_cap     <= '0;
                shift_buf <= '0;
            end else if (load) begin
                n_iss <= '0;
                n_cap <= '0;
            end else begin
                if (rd)
                    n_iss <= n_iss + 3'd1;
                if (rd_pend) begin
                    n_cap     <= n_cap + 3'd1;
                    shift_buf <= cap_word;
                end
            end
            if (load) begin
                word <= direct ? cap_word : shift_buf;
                vld  <= 1'b1;
                cnt  <= cnt + CNT_ONE;
            end else if (bus.word_rdy_i) begin
                vld <= 1'b0;
            end
        end
    end

    assign bus.mbox_rd_o  = rd;
    assign bus.word_o     = word;
    assign bus.word_vld_o = vld;
    assign bus.word_cnt_o = cnt;
    assign bus.partial_o  = (n_iss != 3'd0);
endmodule

// File: tb/tb_mbox_rd_if.sv
// Bench for mbox_rd_if: FIFO model plus byte-group reference for words.
// Directed scenarios followed by a randomized soak.
module tb_mbox_rd_if;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mbox_rd_if_if #(.CNT_W(4)) ifc ();

    mbox_rd_if #(.CNT_W(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (ifc.master)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  fifo[$];
    logic [7:0]  grp[$];
    logic [7:0]  pend;
    int          m_cnt;
    int          npops;
    int          nloads;
    logic        flush, rdy, starve;
    logic        popped, s_vld, loaded;
    logic [31:0] s_word, ld_word, ew;
    logic        prev_vld, prev_rdy;
    logic [31:0] prev_word;
    logic [3:0]  prev_cnt;
    logic [9:0]  pmask, vmask;
    logic [31:0] vword;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        s_vld  = ifc.word_vld_o;
        s_word = ifc.word_o;
        loaded = (ifc.word_cnt_o !== prev_cnt);
        if (loaded) begin
            m_cnt++;
            nloads++;
            chk("grp_full", 32'(grp.size() >= 4), 32'd1);
            if (grp.size() >= 4) begin
                ew = {grp[3], grp[2], grp[1], grp[0]};
                repeat (4) void'(grp.pop_front());
            end else begin
                ew = 32'hDEAD_BEEF;
            end
            chk("load_word", s_word, ew);
            chk("load_vld", 32'(s_vld), 32'd1);
            ld_word = s_word;
        end else if (prev_vld && !prev_rdy) begin
            chk("hold_word", s_word, prev_word);
            chk("hold_vld", 32'(s_vld), 32'd1);
        end else if (prev_vld && prev_rdy) begin
            chk("drop_vld", 32'(s_vld), 32'd0);
        end
        chk("partial", 32'(ifc.partial_o), 32'(grp.size() != 0));
        chk("cnt", 32'(ifc.word_cnt_o), 32'(m_cnt % 16));
        ifc.mbox_di_i    = pend;
        ifc.flush_i      = flush;
        ifc.word_rdy_i   = rdy;
        ifc.mbox_empty_i = starve || (fifo.size() == 0);
        if (flush)
            grp.delete();
        #1;
        popped = ifc.mbox_rd_o;
        chk("pop_empty", 32'(popped & ifc.mbox_empty_i), 32'd0);
        if (flush)
            chk("flush_rd", 32'(popped), 32'd0);
        if (popped && fifo.size() > 0) begin
            pend = fifo.pop_front();
            grp.push_back(pend);
            npops++;
        end
        prev_vld  = s_vld;
        prev_rdy  = rdy;
        prev_word = s_word;
        prev_cnt  = ifc.word_cnt_o;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        flush  = 1'b0;
        rdy    = 1'b0;
        starve = 1'b0;
        fifo.delete();
        grp.delete();
        pend     = 8'h00;
        m_cnt    = 0;
        npops    = 0;
        nloads   = 0;
        ld_word  = 32'h0;
        prev_vld = 1'b0;
        prev_rdy = 1'b0;
        prev_cnt = 4'h0;
        prev_word = 32'h0;
        ifc.mbox_di_i    = 8'h00;
        ifc.mbox_empty_i = 1'b1;
        ifc.flush_i      = 1'b0;
        ifc.word_rdy_i   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_word", ifc.word_o, 32'h0);
        chk("rst_vld", 32'(ifc.word_vld_o), 32'd0);
        chk("rst_cnt", 32'(ifc.word_cnt_o), 32'd0);
        chk("rst_partial", 32'(ifc.partial_o), 32'd0);
        rst = 1'b0;
    endtask

    task automatic push4(input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            fifo.push_back(w[8*i +: 8]);
    endtask

    initial begin
        // byte order and latency
        do_reset();
        push4(32'h1234_5678);
        rdy = 1'b1;
        pmask = '0;
        vmask = '0;
        vword = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            pmask[i] = popped;
            vmask[i] = s_vld;
            if (s_vld)
                vword = s_word;
        end
        chk("t1_pops", 32'(pmask), 32'h00F);
        chk("t1_vld", 32'(vmask), 32'h020);
        chk("t1_word", vword, 32'h1234_5678);
        chk("t1_cnt", 32'(ifc.word_cnt_o), 32'd1);

        // backpressure and HOLD
        do_reset();
        push4(32'h0403_0201);
        push4(32'h0807_0605);
        rdy = 1'b0;
        repeat (20) step();
        chk("t2_word", ifc.word_o, 32'h0403_0201);
        chk("t2_vld", 32'(ifc.word_vld_o), 32'd1);
        chk("t2_pops", 32'(npops), 32'd8);
        chk("t2_rd", 32'(ifc.mbox_rd_o), 32'd0);
        chk("t2_cnt1", 32'(ifc.word_cnt_o), 32'd1);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        step();
        chk("t2_word2", ifc.word_o, 32'h0807_0605);
        chk("t2_cnt2", 32'(ifc.word_cnt_o), 32'd2);
        chk("t2_vld2", 32'(ifc.word_vld_o), 32'd1);

        // starved FIFO mid-word
        do_reset();
        fifo.push_back(8'hAA);
        fifo.push_back(8'hBB);
        rdy = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_nopop", 32'(popped), 32'd0);
            chk("t3_partial", 32'(ifc.partial_o), 32'd1);
        end
        fifo.push_back(8'hCC);
        fifo.push_back(8'hDD);
        repeat (10) step();
        chk("t3_word", ld_word, 32'hDDCC_BBAA);
        chk("t3_cnt", 32'(ifc.word_cnt_o), 32'd1);

        // flush discards a partial word
        do_reset();
        fifo.push_back(8'h11);
        fifo.push_back(8'h22);
        rdy = 1'b1;
        step();
        step();
        push4(32'h6655_4433);
        flush = 1'b1;
        step();
        chk("t4_flush_pop", 32'(popped), 32'd0);
        flush = 1'b0;
        repeat (12) step();
        chk("t4_word", ld_word, 32'h6655_4433);
        chk("t4_cnt", 32'(ifc.word_cnt_o), 32'd1);
        chk("t4_loads", 32'(nloads), 32'd1);

        // asynchronous reset mid-word
        fifo.push_back(8'h99);
        fifo.push_back(8'h98);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("t5_word", ifc.word_o, 32'h0);
        chk("t5_vld", 32'(ifc.word_vld_o), 32'd0);
        chk("t5_cnt", 32'(ifc.word_cnt_o), 32'd0);
        chk("t5_partial", 32'(ifc.partial_o), 32'd0);
        do_reset();
        push4(32'h0403_0201);
        rdy = 1'b1;
        repeat (10) step();
        chk("t5_word2", ld_word, 32'h0403_0201);
        chk("t5_cnt2", 32'(ifc.word_cnt_o), 32'd1);

        // counter wrap with random stalls
        do_reset();
        for (int i = 0; i < 68; i++)
            fifo.push_back(8'($urandom));
        for (int i = 0; i < 2000 && nloads < 17; i++) begin
            rdy    = ($urandom % 4) != 0;
            starve = ($urandom % 5) == 0;
            step();
        end
        chk("t6_loads", 32'(nloads), 32'd17);
        chk("t6_cnt", 32'(ifc.word_cnt_o), 32'd1);

        // random soak with flushes
        for (int i = 0; i < 1500; i++) begin
            rdy    = ($urandom % 3) != 0;
            starve = ($urandom % 6) == 0;
            flush  = ($urandom % 40) == 0;
            if (fifo.size() < 6 && ($urandom % 2) == 1)
                fifo.push_back(8'($urandom));
            step();
        end
        flush  = 1'b0;
        starve = 1'b0;
        rdy    = 1'b1;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mbox_rd_if.md
Name: mbox_rd_if

Overview:
- Read side of the MAILBOX byte stream.
- Pops bytes from the MAILBOX sync FIFO and reassembles them least-significant-byte first into 32-bit words.
- Presents each word on a valid/ready output register to a downstream WB_DW-wide consumer, such as a CPU-side register file or a WOU command decoder.
- Mirrors the writer, which emits each 32-bit word as 4 bytes, LSB first.

Parameters:
- WB_DW, 32: assembled word width; fixed at 4 x WOU_DW.
- WOU_DW, 8: MAILBOX byte width.
- CNT_W, 16: width of the assembled-word counter.

Ports:
- wb_clk_i  in  1  clock; single clock domain.
- wb_rst_i  in  1  asynchronous, active-high reset.
- mbox_rd_o  out  1  MAILBOX FIFO pop strobe.
- mbox_di_i  in  WOU_DW  MAILBOX FIFO read data; valid the cycle after mbox_rd_o.
- mbox_empty_i  in  1  MAILBOX FIFO empty flag.
- flush_i  in  1  synchronous discard of any partially assembled word.
- word_o  out  WB_DW  assembled word, {b3,b2,b1,b0}, where b0 is the first byte popped.
- word_vld_o  out  1  word_o holds an unconsumed word.
- word_rdy_i  in  1  consumer accepts word_o this cycle when word_vld_o=1.
- partial_o  out  1  1..4 bytes of the current word are issued or captured but not yet delivered.
- word_cnt_o  out  CNT_W  count of words loaded into word_o; wraps.

Behaviour:
- Reset (async, wb_rst_i=1): word_o=0, word_vld_o=0, word_cnt_o=0, partial_o=0, internal issue count n_iss=0, capture count n_cap=0, rd_pend=0, shift_buf=0.
- mbox_rd_o is combinational: ~mbox_empty_i & (n_iss<4) & ~flush_i. No pop is ever issued while the FIFO is empty.
- rd_pend <= mbox_rd_o. n_iss increments on each pop.
- Capture: when rd_pend=1, the byte on mbox_di_i is captured as shift_buf <= {mbox_di_i, shift_buf[31:8]} and n_cap increments.
- Output free condition: out_free = ~word_vld_o | word_rdy_i.
- Direct load: when rd_pend=1, n_cap=3 and out_free=1:
  - word_o <= {mbox_di_i, shift_buf[31:8]}; word_vld_o <= 1; word_cnt_o++.
  - n_iss and n_cap are cleared on the same edge.
- Held load: when rd_pend=1, n_cap=3 and out_free=0:
  - The byte goes into shift_buf and n_cap becomes 4 (HOLD).
  - In HOLD, on the first cycle with out_free=1: word_o <= shift_buf, word_vld_o <= 1, word_cnt_o++, n_iss and n_cap cleared.
- Pop gating: no pops are issued while n_iss=4, so a following word never overwrites HOLD.
- Consumption: word_vld_o falls on word_rdy_i=1 unless a load happens in the same cycle, in which case it stays 1 with the new data.
- Latency: the first pop in cycle 0, with 4 back-to-back non-empty cycles and a free output, gives word_vld_o=1 in cycle 5. Sustained throughput is 1 word per 5 cycles.
- FIFO going empty mid-word: assembly pauses with state held, then resumes when data arrives. There is no timeout.
- partial_o = (n_iss != 0).
- flush_i=1:
  - Clears n_iss, n_cap and shift_buf.
  - Any byte landing that cycle via rd_pend is discarded.
  - mbox_rd_o is forced to 0.
  - word_o, word_vld_o and word_cnt_o are untouched; a word already in HOLD is also discarded.
- Simultaneous flush_i and a 4th-byte capture: flush wins, no load occurs and word_cnt_o does not change.
- word_cnt_o wraps from 2^CNT_W-1 to 0.
- Reset mid-word: all state cleared immediately. Bytes already popped are lost.

Test Plan:
- Byte stream order: FIFO holds 78,56,34,12 and word_rdy_i=1 → word_o=0x12345678, word_vld_o high for exactly 1 cycle, word_cnt_o=1, pops in cycles 0-3, valid in cycle 5.
- Backpressure: stream 8 bytes 01..08 with word_rdy_i=0 → word_o=0x04030201 held. Exactly 8 pops occur and HOLD keeps 0x08070605 with mbox_rd_o=0. Raising word_rdy_i for one cycle → word_o=0x08070605 next cycle, word_cnt_o=2.
- Starved FIFO: bytes AA, BB, then mbox_empty_i=1 for 10 cycles, then CC, DD → no pop while empty, partial_o=1 throughout, word_o=0xDDCCBBAA.
- Flush: bytes 11,22 then flush_i=1 for 1 cycle, then 33,44,55,66 → word_o=0x66554433, word_cnt_o=1, no word containing 0x11 or 0x22.
- Reset mid-word: assert wb_rst_i asynchronously after 2 of 4 bytes → all outputs 0 in the same cycle. The next 4 bytes 01..04 give 0x04030201.
- Counter wrap: with CNT_W=4, deliver 17 words → word_cnt_o=1.
